fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the RV32I core.
- Owns the architectural PC register and drives the instruction-memory request/grant/response handshake.
- Delivers each fetched instruction and its PC to decode over a valid/ready interface.
- Accepts redirects (branch, jal, jalr) from execute, including redirects that arrive while a fetch is in flight.
- Non-pipelined: at most one memory transaction outstanding.

---
 rtl/fetch_ctrl.sv | 98 +++++++++
 tb/tb_fetch_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC and runs one imem transaction at a time,
// then presents the fetched word to decode over valid/ready. Redirects may arrive in any state.
module fetch_ctrl #(
  parameter int                 WIDTH    = 32,
  parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [WIDTH-1:0]  imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [WIDTH-1:0]  redirect_target,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [WIDTH-1:0]  if_pc
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

  state_t            state;
  logic [WIDTH-1:0]  pc;
  logic              discard;
  logic [31:0]       instr_q;
  logic [WIDTH-1:0]  target;

  assign target    = {redirect_target[WIDTH-1:2], 2'b00};
  assign imem_addr = pc;
  assign if_pc     = pc;
  assign if_instr  = instr_q;

  // imem_req and if_valid are registered alongside the state so no input reaches them combinationally.
  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all updates see the pre-edge values of each other.
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      discard  <= 1'b0;
      instr_q  <= '0;
      imem_req <= 1'b0;
      if_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) pc <= target;
          state    <= REQ;
          imem_req <= 1'b1;
        end

        REQ: begin
          if (redirect_valid) pc <= target;
          if (imem_gnt) begin
            // The old address was accepted; a simultaneous redirect makes its response stale.
            state    <= WAIT;
            imem_req <= 1'b0;
            discard  <= redirect_valid;
          end
        end

        WAIT: begin
          if (redirect_valid) pc <= target;
          if (imem_rvalid) begin
            discard <= 1'b0;
            if (redirect_valid || discard) begin
              state    <= REQ;
              imem_req <= 1'b1;
            end else begin
              instr_q  <= imem_rdata;
              state    <= OUT;
              if_valid <= 1'b1;
            end
          end else if (redirect_valid) begin
            discard <= 1'b1;
          end
        end

        OUT: begin
          if (redirect_valid || if_ready) begin
            pc       <= redirect_valid ? target : pc + WIDTH'(4);
            state    <= REQ;
            if_valid <= 1'b0;
            imem_req <= 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
          if_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios followed by random traffic,
// all compared every cycle against a transaction-level model of the fetch unit.
module tb_fetch_ctrl;

  localparam int          WIDTH    = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              imem_req;
  logic [WIDTH-1:0]  imem_addr;
  logic              imem_gnt = 1'b0;
  logic              imem_rvalid = 1'b0;
  logic [31:0]       imem_rdata = '0;
  logic              redirect_valid = 1'b0;
  logic [WIDTH-1:0]  redirect_target = '0;
  logic              if_valid;
  logic              if_ready = 1'b0;
  logic [31:0]       if_instr;
  logic [WIDTH-1:0]  if_pc;

  int n_vec = 0;
  int n_bad = 0;

  fetch_ctrl #(.WIDTH(WIDTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  // Reference model in transaction terms: what the fetch unit is currently doing.
  logic        m_starting;   // first cycle out of reset, nothing requested yet
  logic        m_asking;     // a request is being presented to memory
  logic        m_in_flight;  // a granted request awaits its response
  logic        m_stale;      // the in-flight response belongs to an abandoned path
  logic        m_holding;    // an instruction is being offered to decode
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_starting  = 1'b1;
    m_asking    = 1'b0;
    m_in_flight = 1'b0;
    m_stale     = 1'b0;
    m_holding   = 1'b0;
    m_pc        = RESET_PC;
    m_instr     = '0;
  endtask

  task automatic model_clock();
    logic [31:0] tgt;
    tgt = redirect_target & ~32'h3;
    if (rst) begin
      model_reset();
    end else if (m_starting) begin
      if (redirect_valid) m_pc = tgt;
      m_starting = 1'b0;
      m_asking   = 1'b1;
    end else if (m_asking) begin
      if (redirect_valid) m_pc = tgt;
      if (imem_gnt) begin
        m_asking    = 1'b0;
        m_in_flight = 1'b1;
        m_stale     = redirect_valid;
      end
    end else if (m_in_flight) begin
      if (redirect_valid) m_pc = tgt;
      if (imem_rvalid) begin
        m_in_flight = 1'b0;
        if (redirect_valid || m_stale) m_asking = 1'b1;
        else begin
          m_holding = 1'b1;
          m_instr   = imem_rdata;
        end
        m_stale = 1'b0;
      end else if (redirect_valid) begin
        m_stale = 1'b1;
      end
    end else if (m_holding) begin
      if (redirect_valid || if_ready) begin
        m_pc      = redirect_valid ? tgt : m_pc + 32'd4;
        m_holding = 1'b0;
        m_asking  = 1'b1;
      end
    end
  endtask

  // One clock: model consumes the inputs present at the edge, outputs are compared 1 ns later.
  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    check("imem_req", {31'b0, imem_req}, {31'b0, m_asking});
    check("imem_addr", imem_addr, m_pc);
    check("if_valid", {31'b0, if_valid}, {31'b0, m_holding});
    check("if_pc", if_pc, m_pc);
    check("if_instr", if_instr, m_instr);
  endtask

  task automatic drive(input logic gnt, input logic rv, input logic rdy,
                       input logic redir, input logic [31:0] tgt);
    imem_gnt        = gnt;
    imem_rvalid     = rv;
    if_ready        = rdy;
    redirect_valid  = redir;
    redirect_target = tgt;
  endtask

  initial begin
    logic [31:0] held_instr;
    model_reset();

    // Reset state
    rst = 1'b1;
    step(); step();
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_instr", if_instr, 32'd0);

    // Boot: gnt and rvalid immediately available
    rst = 1'b0;
    imem_rdata = 32'h1234_5678;
    drive(1, 0, 1, 0, 0);
    step();
    check("boot_req", {31'b0, imem_req}, 32'd1);
    check("boot_addr", imem_addr, 32'h0);
    drive(1, 1, 1, 0, 0);
    step(); step();
    check("boot_valid", {31'b0, if_valid}, 32'd1);
    check("boot_pc", if_pc, 32'h0);
    check("boot_instr", if_instr, 32'h1234_5678);
    step();
    check("boot_next_addr", imem_addr, 32'h4);

    // Stall in OUT for 5 cycles
    imem_rdata = 32'hCAFE_0004;
    drive(1, 1, 0, 0, 0);
    step(); step();
    held_instr = if_instr;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", {31'b0, if_valid}, 32'd1);
      check("stall_req", {31'b0, imem_req}, 32'd0);
      check("stall_instr", if_instr, 32'hCAFE_0004);
    end
    check("stall_held", if_instr, held_instr);
    if_ready = 1'b1;
    step();
    check("stall_next_addr", imem_addr, 32'h8);

    // Redirect during WAIT: the 0x8 response is dropped
    imem_rdata = 32'hDEAD_0008;
    drive(1, 0, 1, 0, 0);
    step();
    drive(0, 0, 1, 1, 32'h100);
    step();
    drive(0, 1, 1, 0, 0);
    step();
    check("wredir_valid", {31'b0, if_valid}, 32'd0);
    check("wredir_addr", imem_addr, 32'h100);
    imem_rdata = 32'hBEEF_0100;
    drive(1, 0, 1, 0, 0);
    step();
    drive(0, 1, 1, 0, 0);
    step();
    check("wredir_pc", if_pc, 32'h100);
    check("wredir_out", {31'b0, if_valid}, 32'd1);
    step();

    // REQ + gnt + redirect
    drive(1, 0, 1, 1, 32'h40);
    step();
    drive(0, 1, 1, 0, 0);
    step();
    check("reqgnt_valid", {31'b0, if_valid}, 32'd0);
    check("reqgnt_addr", imem_addr, 32'h40);

    // WAIT + rvalid + redirect
    drive(1, 0, 1, 0, 0);
    step();
    drive(0, 1, 1, 1, 32'h80);
    step();
    check("waitrv_valid", {31'b0, if_valid}, 32'd0);
    check("waitrv_addr", imem_addr, 32'h80);

    // OUT + if_ready + redirect with misaligned target
    drive(1, 0, 1, 0, 0);
    step();
    drive(0, 1, 0, 0, 0);
    step();
    drive(0, 0, 1, 1, 32'h203);
    step();
    check("outredir_addr", imem_addr, 32'h200);
    check("outredir_valid", {31'b0, if_valid}, 32'd0);

    // Wrap-around
    drive(0, 0, 1, 1, 32'hFFFF_FFFC);
    step();
    drive(1, 0, 1, 0, 0);
    step();
    drive(0, 1, 0, 0, 0);
    step();
    check("wrap_pc", if_pc, 32'hFFFF_FFFC);
    if_ready = 1'b1;
    step();
    check("wrap_addr", imem_addr, 32'h0);

    // Reset mid-WAIT, stale response afterwards
    drive(1, 0, 1, 0, 0);
    step();
    rst = 1'b1;
    drive(0, 0, 1, 0, 0);
    step();
    rst = 1'b0;
    drive(0, 1, 1, 0, 0);
    step();
    check("rstwait_addr", imem_addr, RESET_PC);
    check("rstwait_valid", {31'b0, if_valid}, 32'd0);
    step();
    check("rstwait_valid2", {31'b0, if_valid}, 32'd0);
    drive(1, 0, 1, 0, 0);
    step();
    drive(0, 1, 1, 0, 0);
    step();
    check("rstwait_fresh", {31'b0, if_valid}, 32'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(0, 99) == 0);
      imem_gnt        = $urandom_range(0, 1) == 1;
      imem_rvalid     = $urandom_range(0, 2) != 0;
      if_ready        = $urandom_range(0, 2) != 0;
      redirect_valid  = ($urandom_range(0, 7) == 0);
      redirect_target = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
      imem_rdata      = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
